// File: rtl/shift_right_unit_if.sv
// ============================================================================
// Module   : shift_right_unit_if
// Purpose  : Operand/result bundle for the registered logical right shifter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface shift_right_unit_if #(
    parameter int WIDTH = 32
);
    // Operands are declared signed; the shifter treats both as raw bit patterns.
    logic signed [WIDTH-1:0] data_in;
    logic signed [WIDTH-1:0] shift_amount;
    logic        [WIDTH-1:0] data_out;

    modport master (
        output data_in,
        output shift_amount,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  shift_amount,
        output data_out
    );
endinterface

`default_nettype wire

// File: rtl/shift_right_unit.sv
// ============================================================================
// Module   : shift_right_unit
// Purpose  : Registered 32-bit logical right shifter (zero fill, 1-cycle latency).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_right_unit #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_BITS = 5
) (
    input  logic              clock,
    input  logic              clear,
    shift_right_unit_if.slave bus
);

    logic [SHAMT_BITS-1:0] w_shamt;
    logic                  w_out_of_range;
    logic [WIDTH-1:0]      w_barrel;
    logic [WIDTH-1:0]      data_out_d;
    logic [WIDTH-1:0]      data_out_q;

    assign w_shamt        = bus.shift_amount[SHAMT_BITS-1:0];
    // Any upper count bit set means the count is >= WIDTH (negatives included).
    assign w_out_of_range = |bus.shift_amount[WIDTH-1:SHAMT_BITS];

    // Barrel stages shift by 1, 2, 4, ... ; unsigned '>>' always zero-fills.
    always_comb begin
        w_barrel = bus.data_in;
        for (int k = 0; k < SHAMT_BITS; k++) begin
            if (w_shamt[k]) begin
                w_barrel = w_barrel >> (1 << k);
            end
        end
    end

    assign data_out_d = w_out_of_range ? '0 : w_barrel;

    always_ff @(posedge clock) begin
        if (clear) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_right_unit.sv
// ============================================================================
// Module   : tb_shift_right_unit
// Purpose  : Scoreboard bench for shift_right_unit with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_right_unit;

    logic clock;
    logic clear;
    int   checks;
    int   errors;
    logic [31:0] exp_q [$];

    shift_right_unit_if #(.WIDTH(32)) bus ();

    shift_right_unit #(
        .WIDTH      (32),
        .SHAMT_BITS (5)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one vector mid-cycle; its result is due after the next rising edge.
    task automatic issue(input logic clr, input logic [31:0] din,
                         input logic [31:0] sh, input logic [31:0] expv);
        @(negedge clock);
        clear            = clr;
        bus.data_in      = din;
        bus.shift_amount = sh;
        exp_q.push_back(expv);
    endtask

    // Monitor: every edge with an outstanding expectation yields one comparison.
    initial begin
        logic [31:0] expv;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                checks++;
                if (bus.data_out !== expv) begin
                    errors++;
                    $display("FAIL data_out check#%0d: got %h expected %h",
                             checks, bus.data_out, expv);
                end
            end
        end
    end

    initial begin
        checks           = 0;
        errors           = 0;
        clear            = 1'b1;
        bus.data_in      = '0;
        bus.shift_amount = '0;

        // Reset, then release with same operands
        issue(1'b1, 32'hFFFF_FFFF, 32'd4, 32'h0000_0000);
        issue(1'b0, 32'hFFFF_FFFF, 32'd4, 32'h0FFF_FFFF);

        // Basic shifts
        issue(1'b0, 32'd5, 32'd3, 32'd0);
        issue(1'b0, 32'd6, 32'd1, 32'd3);
        issue(1'b0, 32'd0, 32'd0, 32'd0);
        issue(1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678);

        // Zero fill, no sign extension
        issue(1'b0, 32'h8000_0000, 32'd31, 32'h0000_0001);
        issue(1'b0, 32'hF000_0000, 32'd4, 32'h0F00_0000);

        // Every stage combination, back-to-back
        for (int n = 0; n < 32; n++) begin
            issue(1'b0, 32'hFFFF_FFFF, n, 32'hFFFF_FFFF >> n);
        end

        // Out-of-range counts
        issue(1'b0, 32'hFFFF_FFFF, 32'd32, 32'h0);
        issue(1'b0, 32'hFFFF_FFFF, 32'd33, 32'h0);
        issue(1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0);

        // Changing stream with mid-stream clear
        issue(1'b0, 32'h1234_5678, 32'd8,  32'h0012_3456);
        issue(1'b0, 32'hA5A5_A5A5, 32'd16, 32'h0000_A5A5);
        issue(1'b0, 32'h8000_0001, 32'd1,  32'h4000_0000);
        issue(1'b0, 32'hDEAD_BEEF, 32'd4,  32'h0DEA_DBEE);
        issue(1'b1, 32'hFFFF_FFFF, 32'd0,  32'h0000_0000);
        issue(1'b0, 32'hDEAD_BEEF, 32'd28, 32'h0000_000D);
        issue(1'b0, 32'h0000_0001, 32'd0,  32'h0000_0001);
        issue(1'b0, 32'hCAFE_F00D, 32'd12, 32'h000C_AFEF);

        // Drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clock);
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
